// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from
// execute, and the instruction hand-off to decode.
// master = fetch stage side, slave = memory/pipeline environment side.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, inst_valid, instruction, pc_out, fetch_err,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, pc_out, fetch_err,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// capture into a small {instruction, pc} FIFO, redirect flush with discard
// accounting for responses still in flight.
// Optional macro IF_MISALIGN_CHK_EN: a redirect to a non-word-aligned PC
// raises a sticky fetch_err and stops fetching until reset.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [CW-1:0] r_osd;
    logic [CW-1:0] r_dsc;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic          r_err;
    logic [31:0]   r_mem_inst [FIFO_DEPTH];
    logic [31:0]   r_mem_pc   [FIFO_DEPTH];

    logic          w_misal;
    logic          w_req;
    logic          w_acc;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [CW:0]   w_credit;
    logic [31:0]   w_target;

`ifdef IF_MISALIGN_CHK_EN
    assign w_misal = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    // Low address bits are ignored: fetch always restarts word aligned.
    assign w_target = {bus.redirect_pc[31:2], 2'b00};

    // Outstanding requests plus buffered entries never exceed the FIFO size,
    // so every returning response is guaranteed a slot.
    assign w_credit = {1'b0, r_osd} + {1'b0, r_cnt};
    assign w_req    = reset && !bus.redirect && !r_err && (w_credit < DEPTH_L);
    assign w_acc    = w_req && bus.imem_gnt;
    // Responses with nothing outstanding (e.g. stale after reset) are ignored.
    assign w_resp   = bus.imem_rvalid && (r_osd != '0);
    assign w_push   = w_resp && (r_dsc == '0) && !bus.redirect && !r_err;
    assign w_valid  = (r_cnt != '0);
    assign w_pop    = w_valid && bus.id_ready;

    // Control state: fetch/response PCs, credit and discard counters, FIFO pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc <= RESET_PC;
            r_rpc <= RESET_PC;
            r_osd <= '0;
            r_dsc <= '0;
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_acc) begin
                r_fpc <= r_fpc + 32'd4;
            end
            case ({w_acc, w_resp})
                2'b10:   r_osd <= r_osd + CW'(1);
                2'b01:   r_osd <= r_osd - CW'(1);
                default: r_osd <= r_osd;
            endcase
            if (bus.redirect) begin
                // Flush wins over any same-cycle push/pop; every response still
                // in flight after this edge belongs to the old path.
                r_fpc <= w_target;
                r_rpc <= w_target;
                r_cnt <= '0;
                r_wp  <= '0;
                r_rp  <= '0;
                r_dsc <= r_osd - CW'(w_resp);
                if (w_misal) begin
                    r_err <= 1'b1;
                end
            end else begin
                if (w_resp && (r_dsc != '0)) begin
                    r_dsc <= r_dsc - CW'(1);
                end
                if (w_push) begin
                    r_rpc <= r_rpc + 32'd4;
                    r_wp  <= r_wp + AW'(1);
                end
                if (w_pop) begin
                    r_rp <= r_rp + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // FIFO storage: data only, validity is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wp] <= bus.imem_rdata;
            r_mem_pc[r_wp]   <= r_rpc;
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fpc;
    assign bus.inst_valid  = w_valid;
    assign bus.instruction = w_valid ? r_mem_inst[r_rp] : NOP;
    assign bus.pc_out      = w_valid ? r_mem_pc[r_rp] : r_rpc;
    assign bus.fetch_err   = r_err;
endmodule
